// File: rtl/system_control_pkg.sv
// rtl/system_control_pkg.sv - shared SystemControl reset-handshake types and constants
package system_control_pkg;

  localparam int unsigned RV_FULL = 3;
  localparam int unsigned RV_INST = 2;
  localparam int unsigned RV_IO   = 1;
  localparam int unsigned RV_DATA = 0;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    STROBE,
    WAIT,
    RESPOND
  } reqState_t;

  localparam logic [1:0] STATUS_DONE     = 2'b00;
  localparam logic [1:0] STATUS_TIMEOUT  = 2'b01;
  localparam logic [1:0] STATUS_EMPTY    = 2'b10;
  localparam logic [1:0] STATUS_RESERVED = 2'b11;

endpackage

// File: rtl/io_reset_priority_enc.sv
// rtl/io_reset_priority_enc.sv - 4-bit reset vector to one-hot, Full > Inst > IO > Data
module io_reset_priority_enc
  import system_control_pkg::*;
(
  input  logic [3:0] vector,
  output logic [3:0] oneHot,
  output logic       empty
);

  always_comb begin
    oneHot = 4'b0000;
    if (vector[RV_FULL])      oneHot[RV_FULL] = 1'b1;
    else if (vector[RV_INST]) oneHot[RV_INST] = 1'b1;
    else if (vector[RV_IO])   oneHot[RV_IO]   = 1'b1;
    else if (vector[RV_DATA]) oneHot[RV_DATA] = 1'b1;
  end

  assign empty = (vector == 4'b0000);

endmodule

// File: rtl/io_reset_requester.sv
// rtl/io_reset_requester.sv - initiator side of the software-reset handshake to the memory flasher
module io_reset_requester
  import system_control_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned COUNT_WIDTH    = 11
) (
  input  logic       clk,
  input  logic       async_rst_n,
  input  logic       clk_en,
  input  logic       ReqValid,
  output logic       ReqReady,
  input  logic [3:0] ReqVector,
  output logic       RespValid,
  input  logic       RespReady,
  output logic [1:0] RespStatus,
  output logic       SoftwareResetOut,
  output logic [3:0] ResetVectorOut,
  input  logic       ResetResponseIn,
  output logic       Busy
);

  reqState_t              state;
  reqState_t              nextState;
  logic [COUNT_WIDTH-1:0] waitCount;
  logic [3:0]             vecReg;
  logic [1:0]             statusReg;
  logic [3:0]             encOneHot;
  logic                   encEmpty;
  logic                   termCount;

  io_reset_priority_enc uEnc (
    .vector (ReqVector),
    .oneHot (encOneHot),
    .empty  (encEmpty)
  );

  assign termCount = (waitCount == COUNT_WIDTH'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n)  state <= IDLE;
    else if (clk_en)   state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (ReqValid) nextState = encEmpty ? RESPOND : ARM;
      ARM:     nextState = STROBE;
      STROBE:  nextState = ResetResponseIn ? RESPOND : WAIT;
      WAIT:    if (ResetResponseIn || termCount) nextState = RESPOND;
      RESPOND: if (RespReady) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // The response window opens with the strobe, so the strobe cycle is counted too.
  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      waitCount <= '0;
      vecReg    <= 4'b0000;
      statusReg <= STATUS_DONE;
    end else if (clk_en) begin
      case (state)
        IDLE: begin
          if (ReqValid) begin
            vecReg    <= encOneHot;
            statusReg <= encEmpty ? STATUS_EMPTY : STATUS_DONE;
          end
        end
        ARM:    waitCount <= '0;
        STROBE: waitCount <= waitCount + COUNT_WIDTH'(1);
        WAIT: begin
          if (ResetResponseIn)  statusReg <= STATUS_DONE;
          else if (termCount)   statusReg <= STATUS_TIMEOUT;
          else                  waitCount <= waitCount + COUNT_WIDTH'(1);
        end
        RESPOND: begin
          if (RespReady) begin
            vecReg    <= 4'b0000;
            statusReg <= STATUS_DONE;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    ReqReady         = (state == IDLE);
    RespValid        = (state == RESPOND);
    SoftwareResetOut = (state == STROBE);
    Busy             = (state != IDLE);
    RespStatus       = statusReg;
    ResetVectorOut   = vecReg;
  end

endmodule
